cpu_clk_sequencer: RTL and testbench
====================================

# cpu_clk_sequencer

Generates the CPU clock for the five-stage pipeline from the board clock, replacing the bare `cpu_clk <= btn_clk` register in the display top level. It supports three behaviours:
- debounced single-step from the pulse switch;
- free-running execution at a divided rate;
- halting on a PC breakpoint observed at the WB stage.

Its status outputs feed the LCD display blocks beside the pipeline PC/valid values.

## Interface
Parameters:
- `HALF_PERIOD`, default 4: board-clock cycles `cpu_clk` stays high, and likewise low, per CPU cycle; legal range 1..255.
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable synchronized samples required to accept a switch level change; legal range 2..2^20.

Ports:
- `clk` — input, 1 bit: board clock, 10 MHz.
- `resetn` — input, 1 bit: asynchronous, active-low reset.
- `btn_clk` — input, 1 bit: raw pulse switch, asynchronous and bouncy.
- `run_en` — input, 1 bit: free-run request (level); synchronized internally with 2 flip-flops.
- `bp_en` — input, 1 bit: breakpoint enable; quasi-static.
- `bp_addr` — input, 32 bits: breakpoint PC; quasi-static.
- `wb_pc` — input, 32 bits: WB-stage PC from the CPU.
- `wb_valid` — input, 1 bit: WB-stage valid bit from the CPU.
- `cpu_clk` — output, 1 bit: registered CPU clock.
- `halted` — output, 1 bit: 1 while in HALT.
- `running` — output, 1 bit: 1 in RUN_HI or RUN_LO.
- `step_count` — output, 32 bits: count of `cpu_clk` rising edges issued.
- `ctrl_state` — output, 3 bits: state encoding.

## Operation
Switch conditioning:
- `btn_clk` passes through a 2-flip-flop synchronizer to give `btn_s`.
- A debounce counter counts while `btn_s` differs from `btn_stable`. It clears whenever they are equal.
- When the count reaches `DEBOUNCE_CYCLES-1`, `btn_stable` takes `btn_s` and the counter clears.
- `step_pulse` is a 1-cycle strobe on each 0→1 transition of `btn_stable`.

State machine (`ctrl_state` encoding; a phase counter `ph` runs 0..`HALF_PERIOD-1` in each HI/LO state):
- IDLE = 0: `cpu_clk`=0.
  - If `run_en` → RUN_HI.
  - Else if `step_pulse` → STEP_HI.
  - `run_en` has priority when both occur together.
- STEP_HI = 1: `cpu_clk`=1; at `ph`=`HALF_PERIOD-1` → STEP_LO.
- STEP_LO = 2: `cpu_clk`=0; at end of phase → IDLE.
- RUN_HI = 3: `cpu_clk`=1; at end of phase → RUN_LO.
- RUN_LO = 4: `cpu_clk`=0; at end of phase, in priority order:
  - `bp_hit` → HALT;
  - else `!run_en` → IDLE;
  - else → RUN_HI.
- HALT = 5: `cpu_clk`=0, `halted`=1.
  - `step_pulse` → STEP_HI; this steps past the breakpoint, and STEP_LO then returns to IDLE.
  - `!run_en` → IDLE.
  - If both occur, the step wins.
- `bp_hit` = `bp_en` && `wb_valid` && (`wb_pc` == `bp_addr`). It is sampled only in the last cycle of RUN_LO.
- `step_pulse` arriving outside IDLE/HALT is discarded, not queued.
- `step_count` increments by 1 on every entry to STEP_HI or RUN_HI and wraps from 0xFFFFFFFF to 0. It is cleared only by reset.
- Encodings 6 and 7 are illegal and return to IDLE on the next clock.

## Timing
- Reset values:
  - `cpu_clk`=0, `halted`=0, `running`=0, `step_count`=0, `ctrl_state`=IDLE;
  - debounce counter=0, `btn_stable`=0, synchronizers=0;
  - `ph`=0.
- All outputs are registered. `cpu_clk` changes in the same cycle `ctrl_state` enters a state.
- Step latency:
  - `btn_stable` rises `DEBOUNCE_CYCLES` cycles after `btn_s` first differs.
  - STEP_HI is entered on the next clock.
  - The full step occupies exactly 2×`HALF_PERIOD` cycles.
- Run: `cpu_clk` period is 2×`HALF_PERIOD` with a 50% duty cycle. The HI→LO and LO→HI phase boundaries are glitch-free.
- After a `bp_hit` decision, HALT is entered at the clock that would have started RUN_HI, so no further rising edge is issued.
- Reset asserted mid-cycle: `cpu_clk` drops asynchronously to 0, leaving a truncated high phase; this is acceptable because the CPU is reset by the same `resetn`.

## Test plan
- Reset, then pulse `btn_clk` 0→1 held for `DEBOUNCE_CYCLES`+10 (`DEBOUNCE_CYCLES`=8, `HALF_PERIOD`=2) → exactly one `cpu_clk` high of 2 cycles then low for 2, `step_count`=1, `ctrl_state` back to 0.
- Bounce `btn_clk` with toggles every 3 cycles for 40 cycles, then hold at 0 → no `cpu_clk` edge, `step_count`=0.
- `run_en`=1 for 100 cycles with `HALF_PERIOD`=2 → period-4 clock, `running`=1; deassert → returns to IDLE after the current LO phase, `step_count`=25±1.
- `bp_en`=1, `bp_addr`=0x0000001C, drive `wb_pc` 0x10,0x14,0x18,0x1C with `wb_valid`=1 while running → `halted`=1 after the LO phase in which `wb_pc`=0x1C, `cpu_clk` stays 0; a subsequent step pulse → one `cpu_clk` pulse, then IDLE.
- `run_en` and `step_pulse` asserted in the same IDLE cycle → RUN_HI; a step pulse during RUN is ignored and `step_count` is unchanged by it.
- Preload `step_count` near wrap by forcing it to 0xFFFFFFFF → one step gives 0; assert `resetn`=0 during STEP_HI → `cpu_clk`=0 and all outputs at reset values immediately.

Source files
------------

// File: rtl/cpu_clk_sequencer.sv
// CPU clock sequencer: turns the board clock into a single-stepped, free-running
// or breakpoint-halted CPU clock, with status outputs for the LCD display.
module cpu_clk_sequencer #(
    parameter int HALF_PERIOD     = 4,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        btn_clk,
    input  logic        run_en,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] wb_pc,
    input  logic        wb_valid,
    output logic        cpu_clk,
    output logic        halted,
    output logic        running,
    output logic [31:0] step_count,
    output logic [2:0]  ctrl_state
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [7:0]      PH_LAST = 8'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STEP_HI = 3'd1,
        S_STEP_LO = 3'd2,
        S_RUN_HI  = 3'd3,
        S_RUN_LO  = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    logic            r_btn_meta;
    logic            r_btn_s;
    logic            r_run_meta;
    logic            r_run_s;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_btn_stable;
    logic            r_btn_stable_d;
    state_t          r_state;
    logic [7:0]      r_ph;
    logic            r_cpu_clk;
    logic            r_halted;
    logic            r_running;
    logic [31:0]     r_step_count;

    state_t          w_next_state;
    logic            w_step_pulse;
    logic            w_bp_hit;
    logic            w_ph_last;
    logic            w_timed;
    logic            w_enter_hi;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
            r_run_meta <= 1'b0;
            r_run_s    <= 1'b0;
        end else begin
            r_btn_meta <= btn_clk;
            r_btn_s    <= r_btn_meta;
            r_run_meta <= run_en;
            r_run_s    <= r_run_meta;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_db_cnt       <= '0;
            r_btn_stable   <= 1'b0;
            r_btn_stable_d <= 1'b0;
        end else begin
            r_btn_stable_d <= r_btn_stable;
            if (r_btn_s == r_btn_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_btn_stable <= r_btn_s;
                r_db_cnt     <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_ONE;
            end
        end
    end

    assign w_step_pulse = r_btn_stable & ~r_btn_stable_d;
    assign w_bp_hit     = bp_en & wb_valid & (wb_pc == bp_addr);
    assign w_ph_last    = (r_ph == PH_LAST);
    assign w_timed      = (r_state == S_STEP_HI) || (r_state == S_STEP_LO) ||
                          (r_state == S_RUN_HI)  || (r_state == S_RUN_LO);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_run_s)           w_next_state = S_RUN_HI;
                else if (w_step_pulse) w_next_state = S_STEP_HI;
            end
            S_STEP_HI: if (w_ph_last) w_next_state = S_STEP_LO;
            S_STEP_LO: if (w_ph_last) w_next_state = S_IDLE;
            S_RUN_HI:  if (w_ph_last) w_next_state = S_RUN_LO;
            S_RUN_LO: begin
                // Halting here replaces the next rising edge, so the CPU stops on the breakpoint.
                if (w_ph_last) begin
                    if (w_bp_hit)      w_next_state = S_HALT;
                    else if (!r_run_s) w_next_state = S_IDLE;
                    else               w_next_state = S_RUN_HI;
                end
            end
            S_HALT: begin
                if (w_step_pulse)  w_next_state = S_STEP_HI;
                else if (!r_run_s) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_enter_hi = (w_next_state != r_state) &&
                        ((w_next_state == S_STEP_HI) || (w_next_state == S_RUN_HI));

    // Outputs are decoded from the next state so they switch together with ctrl_state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_ph      <= 8'd0;
            r_cpu_clk <= 1'b0;
            r_halted  <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cpu_clk <= (w_next_state == S_STEP_HI) || (w_next_state == S_RUN_HI);
            r_halted  <= (w_next_state == S_HALT);
            r_running <= (w_next_state == S_RUN_HI) || (w_next_state == S_RUN_LO);
            if (w_next_state != r_state) r_ph <= 8'd0;
            else if (w_timed)            r_ph <= r_ph + 8'd1;
            else                         r_ph <= 8'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_step_count <= 32'd0;
        end else if (w_enter_hi) begin
            r_step_count <= r_step_count + 32'd1;
        end
    end

    assign cpu_clk    = r_cpu_clk;
    assign halted     = r_halted;
    assign running    = r_running;
    assign step_count = r_step_count;
    assign ctrl_state = r_state;

endmodule

// File: tb/tb_cpu_clk_sequencer.sv
// Self-checking bench for cpu_clk_sequencer: every cycle the DUT outputs are compared
// with a behavioural model of the switch conditioning and clock sequencing rules.
module tb_cpu_clk_sequencer;

    localparam int HP = 2;
    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        btn_clk = 1'b0;
    logic        run_en = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] wb_pc = 32'd0;
    logic        wb_valid = 1'b0;
    logic        cpu_clk;
    logic        halted;
    logic        running;
    logic [31:0] step_count;
    logic [2:0]  ctrl_state;

    int checks = 0;
    int errors = 0;

    cpu_clk_sequencer #(.HALF_PERIOD(HP), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .resetn(resetn), .btn_clk(btn_clk), .run_en(run_en),
        .bp_en(bp_en), .bp_addr(bp_addr), .wb_pc(wb_pc), .wb_valid(wb_valid),
        .cpu_clk(cpu_clk), .halted(halted), .running(running),
        .step_count(step_count), .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    logic [37:0] dutOut;
    assign dutOut = {cpu_clk, halted, running, ctrl_state, step_count};

    // Behavioural model: mode numbers are the visible ctrl_state values; mLeft counts
    // down the cycles remaining in the current half period.
    int          mMode, mLeft, mDiffRun;
    logic [31:0] mCount;
    logic        mS1, mS2, mR1, mR2, mStable, mStablePrev;

    task automatic modelReset();
        mMode = 0; mLeft = 0; mDiffRun = 0; mCount = 32'd0;
        mS1 = 0; mS2 = 0; mR1 = 0; mR2 = 0; mStable = 0; mStablePrev = 0;
    endtask

    // Advances the model by one board clock using the inputs currently driven.
    task automatic modelAdvance();
        bit pulse, hit;
        int nMode;
        pulse = mStable && !mStablePrev;
        hit   = bp_en && wb_valid && (wb_pc == bp_addr);
        nMode = mMode;
        case (mMode)
            0: if (mR2) nMode = 3; else if (pulse) nMode = 1;
            1: if (mLeft == 1) nMode = 2;
            2: if (mLeft == 1) nMode = 0;
            3: if (mLeft == 1) nMode = 4;
            4: if (mLeft == 1) nMode = hit ? 5 : (!mR2 ? 0 : 3);
            5: if (pulse) nMode = 1; else if (!mR2) nMode = 0;
            default: nMode = 0;
        endcase
        if (nMode != mMode) begin
            mLeft = HP;
            if (nMode == 1 || nMode == 3) mCount = mCount + 32'd1;
        end else if (mLeft > 1) begin
            mLeft = mLeft - 1;
        end
        mMode = nMode;
        mStablePrev = mStable;
        if (mS2 != mStable) mDiffRun = mDiffRun + 1;
        else                mDiffRun = 0;
        if (mDiffRun == DB) begin
            mStable  = mS2;
            mDiffRun = 0;
        end
        mS2 = mS1; mS1 = btn_clk;
        mR2 = mR1; mR1 = run_en;
    endtask

    function automatic logic [37:0] expOut();
        return {(mMode == 1 || mMode == 3), (mMode == 5), (mMode == 3 || mMode == 4),
                3'(mMode), mCount};
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        modelReset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dutOut !== 38'd0) begin
                errors++;
                $display("[TB] FAIL reset_values cyc %0d: got %h want %h", i, dutOut, 38'd0);
            end
        end
        resetn = 1'b1;
    endtask

    task automatic test_bounce();
        bit sawHigh = 0;
        for (int i = 0; i < 60; i++) begin
            btn_clk = (i < 40) ? 1'(((i / 3) % 2)) : 1'b0;
            modelAdvance();
            @(negedge clk);
            checks++;
            if (dutOut !== expOut()) begin
                errors++;
                $display("[TB] FAIL bounce cyc %0d: got %h want %h", i, dutOut, expOut());
            end
            if (cpu_clk) sawHigh = 1;
        end
        checks++;
        if (sawHigh || step_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL bounce_no_step: sawHigh %0d count %0d want 0/0", sawHigh, step_count);
        end
    endtask

    task automatic test_single_step();
        int rises = 0, highCycles = 0;
        logic prevClk = 1'b0;
        for (int i = 0; i < 2 * (DB + 10); i++) begin
            btn_clk = (i < DB + 10);
            modelAdvance();
            @(negedge clk);
            checks++;
            if (dutOut !== expOut()) begin
                errors++;
                $display("[TB] FAIL single_step cyc %0d: got %h want %h", i, dutOut, expOut());
            end
            if (cpu_clk && !prevClk) rises++;
            if (cpu_clk) highCycles++;
            prevClk = cpu_clk;
        end
        checks++;
        if (rises != 1 || highCycles != HP || step_count !== 32'd1 || ctrl_state !== 3'd0) begin
            errors++;
            $display("[TB] FAIL single_step_shape: rises %0d high %0d count %0d state %0d want 1/%0d/1/0",
                     rises, highCycles, step_count, ctrl_state, HP);
        end
    endtask

    task automatic test_run();
        logic [31:0] base = mCount;
        int lastRise = -1;
        bit sawRunning = 0;
        logic prevClk = 1'b0;
        for (int i = 0; i < 120; i++) begin
            run_en = (i < 100);
            modelAdvance();
            @(negedge clk);
            checks++;
            if (dutOut !== expOut()) begin
                errors++;
                $display("[TB] FAIL run cyc %0d: got %h want %h", i, dutOut, expOut());
            end
            if (running) sawRunning = 1;
            if (cpu_clk && !prevClk) begin
                if (lastRise >= 0) begin
                    checks++;
                    if (i - lastRise != 2 * HP) begin
                        errors++;
                        $display("[TB] FAIL run_period: got %0d want %0d", i - lastRise, 2 * HP);
                    end
                end
                lastRise = i;
            end
            prevClk = cpu_clk;
        end
        checks++;
        if (!sawRunning || (step_count - base) < 24 || (step_count - base) > 26 || ctrl_state !== 3'd0) begin
            errors++;
            $display("[TB] FAIL run_summary: running %0d edges %0d state %0d want 1/25+-1/0",
                     sawRunning, step_count - base, ctrl_state);
        end
    endtask

    task automatic test_breakpoint();
        logic [31:0] pcs [4] = '{32'h10, 32'h14, 32'h18, 32'h1C};
        logic [31:0] base = mCount;
        int d, idx, firstExit = -1;
        bit haltSeen = 0, exited = 0;
        bp_en = 1'b1; bp_addr = 32'h1C; wb_valid = 1'b1; run_en = 1'b1;
        for (int i = 0; i < 200 && !haltSeen; i++) begin
            d = int'(mCount - base);
            idx = (d <= 1) ? 0 : ((d >= 4) ? 3 : d - 1);
            wb_pc = pcs[idx];
            modelAdvance();
            @(negedge clk);
            checks++;
            if (dutOut !== expOut()) begin
                errors++;
                $display("[TB] FAIL bp_run cyc %0d: got %h want %h", i, dutOut, expOut());
            end
            if (mMode == 5) haltSeen = 1;
        end
        checks++;
        if (!haltSeen || halted !== 1'b1 || cpu_clk !== 1'b0 || (step_count - base) !== 32'd4) begin
            errors++;
            $display("[TB] FAIL bp_halt: halted %0d clk %0d edges %0d want 1/0/4", halted, cpu_clk, step_count - base);
        end
        for (int i = 0; i < 6 + 2 * (DB + 10); i++) begin
            btn_clk = (i >= 6 && i < 6 + DB + 10);
            modelAdvance();
            @(negedge clk);
            checks++;
            if (dutOut !== expOut()) begin
                errors++;
                $display("[TB] FAIL bp_step cyc %0d: got %h want %h", i, dutOut, expOut());
            end
            if (!exited && ctrl_state !== 3'd5) begin
                exited = 1;
                firstExit = int'(ctrl_state);
            end
        end
        checks++;
        if (firstExit != 1) begin
            errors++;
            $display("[TB] FAIL bp_step_exit: got state %0d want 1", firstExit);
        end
        for (int i = 0; i < 12; i++) begin
            run_en = 1'b0;
            modelAdvance();
            @(negedge clk);
            checks++;
            if (dutOut !== expOut()) begin
                errors++;
                $display("[TB] FAIL bp_release cyc %0d: got %h want %h", i, dutOut, expOut());
            end
        end
        bp_en = 1'b0; wb_valid = 1'b0;
    endtask

    task automatic test_run_step_same();
        int firstExit = -1;
        bit exited = 0, sawStep = 0;
        for (int i = 0; i < 90; i++) begin
            btn_clk = (i < 30) || (i >= 45 && i < 60);
            run_en  = (i >= 8 && i < 60);
            modelAdvance();
            @(negedge clk);
            checks++;
            if (dutOut !== expOut()) begin
                errors++;
                $display("[TB] FAIL run_step cyc %0d: got %h want %h", i, dutOut, expOut());
            end
            if (!exited && ctrl_state !== 3'd0) begin
                exited = 1;
                firstExit = int'(ctrl_state);
            end
            if (ctrl_state === 3'd1) sawStep = 1;
        end
        checks++;
        if (firstExit != 3 || sawStep) begin
            errors++;
            $display("[TB] FAIL run_step_priority: first %0d step %0d want 3/0", firstExit, sawStep);
        end
    endtask

    task automatic test_wrap();
        force dut.r_step_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_step_count;
        mCount = 32'hFFFF_FFFF;
        for (int i = 0; i < 2 * (DB + 10); i++) begin
            btn_clk = (i < DB + 10);
            modelAdvance();
            @(negedge clk);
            checks++;
            if (dutOut !== expOut()) begin
                errors++;
                $display("[TB] FAIL wrap cyc %0d: got %h want %h", i, dutOut, expOut());
            end
        end
        checks++;
        if (step_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL wrap_count: got %h want 0", step_count);
        end
    endtask

    task automatic test_reset_mid_step();
        bit inStep = 0;
        for (int i = 0; i < 40 && !inStep; i++) begin
            btn_clk = 1'b1;
            modelAdvance();
            @(negedge clk);
            checks++;
            if (dutOut !== expOut()) begin
                errors++;
                $display("[TB] FAIL pre_reset cyc %0d: got %h want %h", i, dutOut, expOut());
            end
            if (mMode == 1) inStep = 1;
        end
        checks++;
        if (!inStep || cpu_clk !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reach_step_hi: got clk %0d want 1", cpu_clk);
        end
        #2;
        resetn = 1'b0;
        btn_clk = 1'b0;
        modelReset();
        #1;
        checks++;
        if (dutOut !== 38'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h want %h", dutOut, 38'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            modelAdvance();
            @(negedge clk);
            checks++;
            if (dutOut !== expOut()) begin
                errors++;
                $display("[TB] FAIL post_reset cyc %0d: got %h want %h", i, dutOut, expOut());
            end
        end
    endtask

    task automatic test_random();
        int btnHold = 0, runHold = 0;
        bp_en = 1'b1; bp_addr = 32'h20;
        for (int i = 0; i < 1500; i++) begin
            if (btnHold == 0) begin
                btn_clk = 1'($urandom_range(0, 1));
                btnHold = $urandom_range(1, 20);
            end
            if (runHold == 0) begin
                run_en = 1'($urandom_range(0, 1));
                runHold = $urandom_range(1, 60);
            end
            btnHold--; runHold--;
            wb_valid = 1'($urandom_range(0, 1));
            wb_pc    = ($urandom_range(0, 3) == 0) ? 32'h20 : 32'h24;
            modelAdvance();
            @(negedge clk);
            checks++;
            if (dutOut !== expOut()) begin
                errors++;
                $display("[TB] FAIL random cyc %0d: got %h want %h", i, dutOut, expOut());
            end
        end
        btn_clk = 1'b0; run_en = 1'b0; bp_en = 1'b0; wb_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            modelAdvance();
            @(negedge clk);
            checks++;
            if (dutOut !== expOut()) begin
                errors++;
                $display("[TB] FAIL random_settle cyc %0d: got %h want %h", i, dutOut, expOut());
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_single_step();
        test_run();
        test_breakpoint();
        test_run_step_same();
        test_wrap();
        test_reset_mid_step();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
